// File: rtl/battleship_game_ctrl_if.sv
// Shot handshake between the turn sequencer (master) and the board datapath (slave).
interface battleship_game_ctrl_if #(
  parameter int IDX_W = 7
);
  logic             shot_req;
  logic [IDX_W-1:0] shot_cell;
  logic             shot_ack;
  logic             shot_hit;
  logic             shot_repeat;

  modport master (output shot_req, shot_cell, input shot_ack, shot_hit, shot_repeat);
  modport slave  (input shot_req, shot_cell, output shot_ack, shot_hit, shot_repeat);
endinterface

// File: rtl/battleship_game_ctrl.sv
// Battleship turn sequencer: cursor, fire handshake, scoring, player alternation,
// per-turn timeout and winner detection.
module battleship_game_ctrl #(
  parameter int GRID_W       = 10,
  parameter int GRID_H       = 10,
  parameter int IDX_W        = 7,
  parameter int WIN_HITS     = 17,
  parameter int TURN_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_btn,
  input  logic                   reset_btn,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_select,
  output logic [IDX_W-1:0]       selected_cell,
  battleship_game_ctrl_if.master shot_if,
  output logic                   player,
  output logic [4:0]             hits_p0,
  output logic [4:0]             hits_p1,
  output logic                   game_over,
  output logic                   winner,
  output logic                   turn_timeout
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_AIM    = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_SWITCH = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int TW = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;

  localparam logic [RW-1:0] ROW_MAX = RW'(GRID_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(GRID_W - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TURN_TIMEOUT - 1);
  localparam logic [4:0]    WIN     = 5'(WIN_HITS);

  logic [2:0]       state_q, state_d;
  logic             player_q, player_d;
  logic [4:0]       hits0_q, hits0_d, hits1_q, hits1_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0] cell_q, cell_d;
  logic [4:0]       hits_cur, hits_nxt;

  assign selected_cell    = IDX_W'(row_q) * IDX_W'(GRID_W) + IDX_W'(col_q);
  assign shot_if.shot_req  = (state_q == S_FIRE);
  assign shot_if.shot_cell = cell_q;
  assign player           = player_q;
  assign hits_p0          = hits0_q;
  assign hits_p1          = hits1_q;
  assign game_over        = (state_q == S_OVER);
  assign winner           = game_over & player_q;

  assign hits_cur = player_q ? hits1_q : hits0_q;
  assign hits_nxt = (hits_cur == WIN) ? hits_cur : hits_cur + 5'd1;

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    hits0_d      = hits0_q;
    hits1_d      = hits1_q;
    row_d        = row_q;
    col_d        = col_q;
    timer_d      = timer_q;
    cell_d       = cell_q;
    turn_timeout = 1'b0;

    // reset_btn overrides everything, including an outstanding fire request
    if (reset_btn) begin
      state_d  = S_IDLE;
      player_d = 1'b0;
      hits0_d  = '0;
      hits1_d  = '0;
      row_d    = '0;
      col_d    = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_btn) begin
            state_d  = S_AIM;
            player_d = 1'b0;
            hits0_d  = '0;
            hits1_d  = '0;
            row_d    = '0;
            col_d    = '0;
            timer_d  = '0;
          end
        end
        S_AIM: begin
          // select outranks both the timeout and any same-cycle move
          if (btn_select) begin
            state_d = S_FIRE;
            cell_d  = selected_cell;
          end else if (TURN_TIMEOUT != 0 && timer_q == T_LAST) begin
            state_d      = S_SWITCH;
            turn_timeout = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
            if (btn_up) begin
              if (row_q != '0) row_d = row_q - 1'b1;
            end else if (btn_down) begin
              if (row_q != ROW_MAX) row_d = row_q + 1'b1;
            end else if (btn_left) begin
              if (col_q != '0) col_d = col_q - 1'b1;
            end else if (btn_right) begin
              if (col_q != COL_MAX) col_d = col_q + 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (shot_if.shot_ack) begin
            if (shot_if.shot_repeat) begin
              state_d = S_AIM;
              timer_d = '0;
            end else if (shot_if.shot_hit) begin
              if (player_q) hits1_d = hits_nxt;
              else          hits0_d = hits_nxt;
              state_d = (hits_nxt == WIN) ? S_OVER : S_SWITCH;
            end else begin
              state_d = S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          player_d = ~player_q;
          timer_d  = '0;
          state_d  = S_AIM;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      player_q <= 1'b0;
      hits0_q  <= '0;
      hits1_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      timer_q  <= '0;
      cell_q   <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      hits0_q  <= hits0_d;
      hits1_q  <= hits1_d;
      row_q    <= row_d;
      col_q    <= col_d;
      timer_q  <= timer_d;
      cell_q   <= cell_d;
    end
  end
endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl: default-timeout instance plus an 8-cycle-timeout instance.
module tb_battleship_game_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_btn = 0, reset_btn = 0, btn_up = 0, btn_down = 0;
  logic btn_left = 0, btn_right = 0, btn_select = 0;

  logic [6:0] sel_a, sel_b;
  logic       player_a, player_b, over_a, over_b, win_a, win_b, to_a, to_b;
  logic [4:0] h0_a, h1_a, h0_b, h1_b;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  battleship_game_ctrl_if #(.IDX_W(7)) sif_a ();
  battleship_game_ctrl_if #(.IDX_W(7)) sif_b ();

  battleship_game_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .reset_btn(reset_btn),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .selected_cell(sel_a), .shot_if(sif_a), .player(player_a),
    .hits_p0(h0_a), .hits_p1(h1_a), .game_over(over_a), .winner(win_a), .turn_timeout(to_a)
  );

  battleship_game_ctrl #(.TURN_TIMEOUT(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .reset_btn(reset_btn),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .selected_cell(sel_b), .shot_if(sif_b), .player(player_b),
    .hits_p0(h0_b), .hits_p1(h1_b), .game_over(over_b), .winner(win_b), .turn_timeout(to_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bits: start, reset_btn, up, down, left, right, select
  task automatic press(input logic [6:0] b);
    {start_btn, reset_btn, btn_up, btn_down, btn_left, btn_right, btn_select} = b;
    tick();
    {start_btn, reset_btn, btn_up, btn_down, btn_left, btn_right, btn_select} = '0;
  endtask

  task automatic reply(input logic hit, input logic rep);
    sif_a.shot_ack = 1'b1; sif_a.shot_hit = hit; sif_a.shot_repeat = rep;
    tick();
    sif_a.shot_ack = 1'b0; sif_a.shot_hit = 1'b0; sif_a.shot_repeat = 1'b0;
  endtask

  localparam logic [6:0] P_START = 7'b1000000, P_RST = 7'b0100000, P_UP = 7'b0010000;
  localparam logic [6:0] P_DOWN = 7'b0001000, P_LEFT = 7'b0000100, P_RIGHT = 7'b0000010;
  localparam logic [6:0] P_SEL = 7'b0000001;

  initial begin
    sif_a.shot_ack = 0; sif_a.shot_hit = 0; sif_a.shot_repeat = 0;
    sif_b.shot_ack = 0; sif_b.shot_hit = 0; sif_b.shot_repeat = 0;
    tick(); tick();
    check("rst_sel", 32'(sel_a), 0);
    check("rst_req", 32'(sif_a.shot_req), 0);
    check("rst_cell", 32'(sif_a.shot_cell), 0);
    check("rst_player", 32'(player_a), 0);
    check("rst_hits", 32'({h0_a, h1_a}), 0);
    check("rst_over", 32'({over_a, win_a, to_a}), 0);
    reset_n = 1'b1;
    tick();

    // basic turn: cursor to (1,2), fire, miss
    press(P_START);
    press(P_RIGHT); press(P_RIGHT); press(P_DOWN);
    check("t1_sel", 32'(sel_a), 12);
    press(P_SEL);
    check("t1_req", 32'(sif_a.shot_req), 1);
    check("t1_cell", 32'(sif_a.shot_cell), 12);
    reply(1'b0, 1'b0);
    check("t1_req_drop", 32'(sif_a.shot_req), 0);
    check("t1_player_sw", 32'(player_a), 0);
    tick();
    check("t1_player", 32'(player_a), 1);

    // cursor saturation and priority
    press(P_UP); press(P_LEFT); press(P_LEFT);
    check("t2_home", 32'(sel_a), 0);
    press(P_LEFT);
    check("t2_left_sat", 32'(sel_a), 0);
    press(P_UP);
    check("t2_up_sat", 32'(sel_a), 0);
    for (int i = 0; i < 9; i++) press(P_RIGHT);
    check("t2_col9", 32'(sel_a), 9);
    press(P_RIGHT);
    check("t2_right_sat", 32'(sel_a), 9);
    for (int i = 0; i < 9; i++) press(P_DOWN);
    check("t2_row9", 32'(sel_a), 99);
    press(P_DOWN);
    check("t2_down_sat", 32'(sel_a), 99);
    press(P_UP | P_DOWN | P_LEFT);
    check("t2_priority", 32'(sel_a), 89);
    press(P_SEL | P_RIGHT);
    check("t2_sel_move_cell", 32'(sif_a.shot_cell), 89);
    check("t2_sel_move_cursor", 32'(sel_a), 89);

    // repeat reply overrides hit
    reply(1'b1, 1'b1);
    check("t3_req", 32'(sif_a.shot_req), 0);
    check("t3_hits", 32'({h0_a, h1_a}), 0);
    check("t3_player", 32'(player_a), 1);
    tick();
    check("t3_player_hold", 32'(player_a), 1);
    press(P_LEFT);
    check("t3_in_aim", 32'(sel_a), 88);
    press(P_SEL); reply(1'b0, 1'b0); tick();
    check("t3_to_p0", 32'(player_a), 0);

    // player 0 wins with 17 hits, player 1 missing in between
    for (int i = 0; i < 17; i++) begin
      press(P_SEL);
      reply(1'b1, 1'b0);
      if (i == 15) check("t4_hits16", 32'(h0_a), 16);
      if (i < 16) begin
        tick();
        press(P_SEL); reply(1'b0, 1'b0); tick();
      end
    end
    check("t4_over", 32'(over_a), 1);
    check("t4_winner", 32'(win_a), 0);
    check("t4_hits_p0", 32'(h0_a), 17);
    check("t4_hits_p1", 32'(h1_a), 0);
    press(P_RIGHT);
    check("t4_frozen", 32'(sel_a), 88);
    press(P_START);
    check("t4_restart_over", 32'(over_a), 0);
    check("t4_restart_hits", 32'(h0_a), 0);
    check("t4_restart_sel", 32'(sel_a), 0);
    press(P_RIGHT);
    press(P_START);
    check("t4_start_ignored", 32'(sel_a), 1);

    // reset_btn during an outstanding shot
    press(P_SEL);
    check("t6_req", 32'(sif_a.shot_req), 1);
    press(P_RST);
    check("t6_req_drop", 32'(sif_a.shot_req), 0);
    reply(1'b1, 1'b0);
    check("t6_late_ack_hits", 32'(h0_a), 0);
    check("t6_late_ack_req", 32'(sif_a.shot_req), 0);
    press(P_SEL);
    check("t6_idle_sel", 32'(sif_a.shot_req), 0);

    // 8-cycle timeout instance
    press(P_RST);
    press(P_START);
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_pulse_c7", 32'(to_b), 0);
    tick();
    check("t5_pulse_c8", 32'(to_b), 1);
    check("t5_player_before", 32'(player_b), 0);
    tick();
    check("t5_pulse_once", 32'(to_b), 0);
    tick();
    check("t5_player_toggled", 32'(player_b), 1);
    for (int i = 0; i < 7; i++) tick();
    btn_select = 1'b1;
    #1;
    check("t5_sel_beats_to", 32'(to_b), 0);
    tick();
    btn_select = 1'b0;
    check("t5_sel_fire", 32'(sif_b.shot_req), 1);
    check("t5_sel_player", 32'(player_b), 1);

    // asynchronous reset mid-AIM
    press(P_RST); press(P_START); press(P_RIGHT);
    check("t6_pre_rstn", 32'(sel_a), 1);
    reset_n = 1'b0;
    #1;
    check("t6_rstn_sel", 32'(sel_a), 0);
    check("t6_rstn_outs", 32'({sif_a.shot_req, player_a, h0_a, h1_a, over_a, win_a, to_a}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
